// File: rtl/arvi_arb_pkg.sv
// arvi_arb_pkg: shared types, widths and the round-robin pick function for the memory arbiters
package arvi_arb_pkg;

    localparam int XLEN      = 32;
    localparam int BYTE_EN_W = 4;
    localparam int MAX_M     = 8;
    localparam int IDX_W     = 3;

    typedef enum logic {IDLE, BUSY} state_t;

    // One-hot grant for the first requester at or after (last+1) mod n, wrapping.
    // Scanning from the farthest slot back to the nearest lets the nearest win without a found flag.
    function automatic logic [MAX_M-1:0] rr_pick(input logic [MAX_M-1:0] req, input logic [IDX_W-1:0] last, input int n);
        logic [MAX_M-1:0] g;
        int idx;
        g = '0;
        for (int i = n; i >= 1; i--) begin
            idx = (int'(last) + i) % n;
            if (req[idx]) g = MAX_M'(1) << idx;
        end
        return g;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker with a registered last-owner pointer
module rr_arbiter
    import arvi_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    input  logic         i_upd,
    input  logic [N-1:0] i_owner,
    output logic [N-1:0] o_pick
);

    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] owner_idx;

    // Encode the one-hot owner so the pointer can be loaded when a transaction ends
    always_comb begin
        owner_idx = '0;
        for (int k = 0; k < N; k++)
            if (i_owner[k]) owner_idx = IDX_W'(k);
    end

    assign o_pick = N'(rr_pick(MAX_M'(i_req), last, N));

    // Pointer starts at the highest index so master 0 wins the first arbitration
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) last <= IDX_W'(N - 1);
        else if (i_upd) last <= owner_idx;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one DM_* data-memory port between several requesters
module dmem_arbiter
    import arvi_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_MASTERS-1:0]          i_m_rd_en,
    input  logic [NUM_MASTERS-1:0]          i_m_wr_en,
    input  logic [NUM_MASTERS*XLEN-1:0]     i_m_addr,
    input  logic [NUM_MASTERS*XLEN-1:0]     i_m_wd,
    input  logic [NUM_MASTERS*BYTE_EN_W-1:0] i_m_byte_en,
    output logic [XLEN-1:0]                 o_m_rdata,
    output logic [NUM_MASTERS-1:0]          o_m_ready,
    output logic [NUM_MASTERS-1:0]          o_m_err,
    output logic [NUM_MASTERS-1:0]          o_grant,
    output logic                            o_busy,
    output logic [XLEN-1:0]                 o_DM_Addr,
    output logic [XLEN-1:0]                 o_DM_Wd,
    output logic                            o_DM_Wen,
    output logic                            o_DM_MemRead,
    output logic [BYTE_EN_W-1:0]            o_DM_byte_en,
    input  logic [XLEN-1:0]                 i_DM_ReadData,
    input  logic                            i_DM_data_ready
);

    state_t                 state, state_nx;
    logic [NUM_MASTERS-1:0] grant, grant_nx, req, pick;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic                   busy, g_req, g_wr, g_rd, done, wdraw, tmo, upd;

    assign req   = i_m_rd_en | i_m_wr_en;
    assign busy  = state == BUSY;
    assign g_req = |(req & grant);
    assign g_wr  = |(i_m_wr_en & grant);
    assign g_rd  = |(i_m_rd_en & grant);
    // Completion beats withdrawal and timeout; withdrawal beats timeout so a dropped request never gets an err
    assign done  = busy & i_DM_data_ready;
    assign wdraw = busy & ~i_DM_data_ready & ~g_req;
    assign tmo   = (TIMEOUT != 0) && busy && !i_DM_data_ready && g_req && cnt == CNT_W'(TIMEOUT - 1);
    assign upd   = done | wdraw | tmo;

    rr_arbiter #(.N(NUM_MASTERS)) u_rr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (req),
        .i_upd   (upd),
        .i_owner (grant),
        .o_pick  (pick)
    );

    // Route the owner's address, data and byte enables to memory; all zero while idle
    always_comb begin
        o_DM_Addr    = '0;
        o_DM_Wd      = '0;
        o_DM_byte_en = '0;
        for (int k = 0; k < NUM_MASTERS; k++)
            if (busy && grant[k]) begin
                o_DM_Addr    = i_m_addr[k*XLEN +: XLEN];
                o_DM_Wd      = i_m_wd[k*XLEN +: XLEN];
                o_DM_byte_en = i_m_byte_en[k*BYTE_EN_W +: BYTE_EN_W];
            end
    end

    assign o_DM_Wen     = busy & g_wr;
    assign o_DM_MemRead = busy & g_rd & ~g_wr;
    assign o_m_ready    = done ? grant : '0;
    assign o_m_rdata    = done ? i_DM_ReadData : '0;
    assign o_m_err      = tmo ? grant : '0;
    assign o_grant      = grant;
    assign o_busy       = busy;

    // State, owner and timeout counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            grant <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            cnt   <= cnt_nx;
        end
    end

    // Grant on any request when idle; hold the grant until completion, withdrawal or timeout
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        cnt_nx   = cnt;
        if (!busy) begin
            if (|req) begin
                state_nx = BUSY;
                grant_nx = pick;
                cnt_nx   = '0;
            end
        end else if (upd) begin
            state_nx = IDLE;
            grant_nx = '0;
        end else begin
            cnt_nx = cnt + 1'b1;
        end
    end

endmodule
